// File: rtl/snos_pkg.sv
// rtl/snos_pkg.sv - shared types and helpers for the NOS DAC multi-channel serializer
// Contents:
//   NOS_BITNUM    output word width selector (NOS16/18/20/24)
//   nos_width()   maps a NOS_BITNUM code to its bit count
//   snos_state_t  frame FSM state encoding
package snos_pkg;

    typedef enum logic [1:0] {
        NOS16 = 2'd0,
        NOS18 = 2'd1,
        NOS20 = 2'd2,
        NOS24 = 2'd3
    } NOS_BITNUM;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_SHIFT = 2'd2,
        S_LATCH = 2'd3
    } snos_state_t;

    function automatic logic [4:0] nos_width(input NOS_BITNUM b);
        case (b)
            NOS16:   return 5'd16;
            NOS18:   return 5'd18;
            NOS20:   return 5'd20;
            default: return 5'd24;
        endcase
    endfunction

endpackage

// File: rtl/nos_dac_mc_serializer_if.sv
// rtl/nos_dac_mc_serializer_if.sv - sample input handshake bundle for the NOS DAC serializer
// Signals:
//   s_data   CHANNELS*SAMPLE_W  channel c at [c*SAMPLE_W +: SAMPLE_W], MSB-aligned
//   s_valid  1                  sample frame valid
//   s_ready  1                  serializer can accept a sample frame
// Modports: master (sample source), slave (serializer)
interface nos_dac_mc_serializer_if #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 32
);
    logic [CHANNELS*SAMPLE_W-1:0] s_data;
    logic                         s_valid;
    logic                         s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/snos_sync_fifo.sv
// rtl/snos_sync_fifo.sv - synchronous first-word-fall-through FIFO
// Parameters: WIDTH entry width, DEPTH entry count (power of 2, >=2)
// Ports:
//   clk, reset   clock, synchronous active-high reset (flushes pointers and count)
//   push, wdata  write request and data; ignored when full
//   pop, rdata   read request; rdata always shows the oldest entry; ignored when empty
//   full, empty  derived from the registered occupancy count
module snos_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/nos_dac_mc_serializer.sv
// rtl/nos_dac_mc_serializer.sv - multi-channel NOS DAC frame serializer
// Buffers parallel sample frames and emits one NOS frame (BCK, per-channel serial data, LE) per fs_tick.
// Optional macro SNOS_UNDERRUN_CNT_EN adds a saturating underrun counter output.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   s_if          slave side of the sample handshake (s_data/s_valid/s_ready)
//   fs_tick       1-clk frame start pulse
//   nos_bitnum    output word width, sampled at frame start
//   bck_cont      1 = BCK free-runs outside SHIFT
//   mute          1 = frame carries zero words (sampled at frame start)
//   bck, sdata    NOS bit clock and serial data (MSB first, changes with BCK low)
//   le            latch enable, one BCK period after the last bit
//   empty         FIFO empty
//   underrun      1-clk pulse: frame started with FIFO empty
//   late          1-clk pulse: fs_tick while a frame is in progress
//   underrun_cnt  (SNOS_UNDERRUN_CNT_EN only) saturating underrun count
module nos_dac_mc_serializer
    import snos_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int SAMPLE_W   = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int BCK_DIV    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    nos_dac_mc_serializer_if.slave  s_if,
    input  logic                    fs_tick,
    input  NOS_BITNUM               nos_bitnum,
    input  logic                    bck_cont,
    input  logic                    mute,
    output logic                    bck,
    output logic [CHANNELS-1:0]     sdata,
    output logic                    le,
    output logic                    empty,
    output logic                    underrun,
    output logic                    late
`ifdef SNOS_UNDERRUN_CNT_EN
    ,
    output logic [15:0]             underrun_cnt
`endif
);
    localparam int DW    = CHANNELS * SAMPLE_W;
    localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int LAT_W = $clog2(2 * BCK_DIV);

    snos_state_t      state;
    snos_state_t      state_next;
    logic             ready_en;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [DW-1:0]    fifo_rdata;
    logic [DW-1:0]    hold;
    logic [DW-1:0]    frame_word;
    logic [DW-1:0]    shreg;
    logic [4:0]       n_bits;
    logic [4:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic             bck_r;
    logic             bck_fall;
    logic             underrun_r;
    logic             late_r;
    logic             frame_start;

    // ready_en keeps s_ready low through reset and the edge that releases it
    assign s_if.s_ready = ready_en && !fifo_full;
    assign push         = s_if.s_valid && s_if.s_ready;
    assign pop          = frame_start && !fifo_empty;
    // an empty FIFO at frame start re-sends whatever the hold register has
    assign frame_word   = fifo_empty ? hold : fifo_rdata;
    // asserted on the cycle whose closing edge drives BCK low
    assign bck_fall     = bck_r && (div_cnt == DIV_W'(BCK_DIV - 1));

    assign bck      = bck_r;
    assign empty    = fifo_empty;
    assign underrun = underrun_r;
    assign late     = late_r;

    snos_sync_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (s_if.s_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        le          = 1'b0;
        sdata       = '0;
        case (state)
            S_IDLE: begin
                if (fs_tick) begin
                    frame_start = 1'b1;
                    state_next  = S_ALIGN;
                end
            end
            S_ALIGN: begin
                // stopped BCK: divider restarts now; free-running BCK: join at a falling edge
                if (!bck_cont || bck_fall) state_next = S_SHIFT;
            end
            S_SHIFT: begin
                for (int c = 0; c < CHANNELS; c++) sdata[c] = shreg[c*SAMPLE_W + SAMPLE_W - 1];
                if (bck_fall && (bit_cnt == n_bits - 5'd1)) state_next = S_LATCH;
            end
            S_LATCH: begin
                le = 1'b1;
                if (lat_cnt == LAT_W'(2 * BCK_DIV - 1)) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_en   <= 1'b0;
            hold       <= '0;
            shreg      <= '0;
            n_bits     <= 5'd16;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            bck_r      <= 1'b0;
            lat_cnt    <= '0;
            underrun_r <= 1'b0;
            late_r     <= 1'b0;
        end else begin
            ready_en   <= 1'b1;
            underrun_r <= frame_start && fifo_empty;
            late_r     <= fs_tick && (state != S_IDLE);

            // the full sample is loaded; only its top n_bits are ever shifted out
            if (frame_start) begin
                hold    <= frame_word;
                shreg   <= mute ? '0 : frame_word;
                n_bits  <= nos_width(nos_bitnum);
                bit_cnt <= '0;
            end else if ((state == S_SHIFT) && bck_fall) begin
                for (int c = 0; c < CHANNELS; c++)
                    shreg[c*SAMPLE_W +: SAMPLE_W] <= {shreg[c*SAMPLE_W +: SAMPLE_W-1], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
            end

            // BCK divider: held low and cleared whenever BCK is not free-running outside SHIFT
            if (!bck_cont && (state != S_SHIFT)) begin
                bck_r   <= 1'b0;
                div_cnt <= '0;
            end else if (div_cnt == DIV_W'(BCK_DIV - 1)) begin
                bck_r   <= !bck_r;
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            lat_cnt <= (state == S_LATCH) ? lat_cnt + 1'b1 : '0;
        end
    end

`ifdef SNOS_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            underrun_cnt <= '0;
        else if (frame_start && fifo_empty && (underrun_cnt != 16'hFFFF))
            underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif

endmodule
